// File: rtl/serv_wb_arbiter.sv
// Fixed-priority three-master Wishbone arbiter (debug > dbus > ibus) with a
// per-transfer watchdog that forces termination when the slave never acks.
module serv_wb_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dm_adr,
  input  logic [31:0] i_dm_dat,
  input  logic [3:0]  i_dm_sel,
  input  logic        i_dm_we,
  input  logic        i_dm_cyc,
  output logic [31:0] o_dm_rdt,
  output logic        o_dm_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_timeout,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, GNT_DM, GNT_D, GNT_I} state_t;

  localparam int          NM       = 3;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;

  // Master request bundles, index 0 = debug, 1 = dbus, 2 = ibus.
  logic [31:0] m_adr [NM];
  logic [31:0] m_dat [NM];
  logic [3:0]  m_sel [NM];
  logic        m_we  [NM];
  logic        m_cyc [NM];
  logic [31:0] m_rdt [NM];
  logic [NM-1:0] m_ack;
  logic [NM-1:0] gnt_oh;

  assign m_adr[0] = i_dm_adr;
  assign m_dat[0] = i_dm_dat;
  assign m_sel[0] = i_dm_sel;
  assign m_we[0]  = i_dm_we;
  assign m_cyc[0] = i_dm_cyc;

  assign m_adr[1] = i_dbus_adr;
  assign m_dat[1] = i_dbus_dat;
  assign m_sel[1] = i_dbus_sel;
  assign m_we[1]  = i_dbus_we;
  assign m_cyc[1] = i_dbus_cyc;

  // The instruction bus is a fixed full-word read.
  assign m_adr[2] = i_ibus_adr;
  assign m_dat[2] = 32'h0;
  assign m_sel[2] = 4'hf;
  assign m_we[2]  = 1'b0;
  assign m_cyc[2] = i_ibus_cyc;

  // Selected master, zero when nobody holds the grant.
  logic [31:0] sel_adr, sel_dat;
  logic [3:0]  sel_sel;
  logic        sel_we, sel_cyc;
  logic        xfer_done, xfer_tmo;
  logic        rsp_ack;
  logic [31:0] rsp_rdt;

  always_comb begin
    sel_adr = 32'h0;
    sel_dat = 32'h0;
    sel_sel = 4'h0;
    sel_we  = 1'b0;
    sel_cyc = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_oh[i]) begin
        sel_adr = m_adr[i];
        sel_dat = m_dat[i];
        sel_sel = m_sel[i];
        sel_we  = m_we[i];
        sel_cyc = m_cyc[i];
      end
    end
  end

  // sel_cyc is already 0 in IDLE, so stray acks there produce nothing.
  assign xfer_done = sel_cyc & i_wb_ack;
  assign xfer_tmo  = sel_cyc & ~i_wb_ack & (cnt_reg == CNT_LAST);
  assign rsp_ack   = xfer_done | xfer_tmo;
  assign rsp_rdt   = xfer_done ? i_wb_rdt : 32'h0;

  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_master
      assign gnt_oh[gi] = (state_reg == state_t'(2'(gi + 1)));
      assign m_ack[gi]  = gnt_oh[gi] & rsp_ack;
      assign m_rdt[gi]  = gnt_oh[gi] ? rsp_rdt : 32'h0;
    end
  endgenerate

  assign o_dm_ack   = m_ack[0];
  assign o_dm_rdt   = m_rdt[0];
  assign o_dbus_ack = m_ack[1];
  assign o_dbus_rdt = m_rdt[1];
  assign o_ibus_ack = m_ack[2];
  assign o_ibus_rdt = m_rdt[2];

  assign o_wb_adr  = sel_adr;
  assign o_wb_dat  = sel_dat;
  assign o_wb_sel  = sel_sel;
  assign o_wb_we   = sel_we;
  assign o_wb_cyc  = sel_cyc & ~xfer_tmo;
  assign o_timeout = xfer_tmo;
  assign o_busy    = (state_reg != IDLE);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        cnt_next = 16'h0;
        if (i_dm_cyc)        state_next = GNT_DM;
        else if (i_dbus_cyc) state_next = GNT_D;
        else if (i_ibus_cyc) state_next = GNT_I;
      end
      GNT_DM, GNT_D, GNT_I: begin
        // Abort, completion and watchdog expiry all release the bus.
        if (!sel_cyc || rsp_ack) begin
          state_next = IDLE;
          cnt_next   = 16'h0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 16'h0;
      end
    endcase
  end

endmodule

// File: doc/serv_wb_arbiter.md
# serv_wb_arbiter

Three-master Wishbone arbiter that shares one memory port between the SERV debug module, the core data bus and the core instruction bus. It sits directly outside `serv_top` and replaces the separate ibus/dbus memory ports. It grants one master at a time with fixed priority: debug first, then dbus, then ibus. A watchdog terminates any transfer the slave never acknowledges, so a stuck slave cannot hang the core or the debugger.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles a granted transfer may wait for `i_wb_ack` before forced termination. Legal range 2..65535.

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_dm_adr`  in  32  debug master address
- `i_dm_dat`  in  32  debug master write data
- `i_dm_sel`  in  4  debug master byte select
- `i_dm_we`  in  1  debug master write enable
- `i_dm_cyc`  in  1  debug master request
- `o_dm_rdt`  out  32  debug master read data
- `o_dm_ack`  out  1  debug master acknowledge
- `i_dbus_adr`, `i_dbus_dat`, `i_dbus_sel`, `i_dbus_we`, `i_dbus_cyc`  in  32/32/4/1/1  core data master; same meanings as the `dm` inputs
- `o_dbus_rdt`, `o_dbus_ack`  out  32/1  core data master response
- `i_ibus_adr`  in  32  core instruction address
- `i_ibus_cyc`  in  1  core instruction request; always a read, sel=4'hf
- `o_ibus_rdt`, `o_ibus_ack`  out  32/1  core instruction response
- `o_wb_adr`, `o_wb_dat`, `o_wb_sel`, `o_wb_we`, `o_wb_cyc`  out  32/32/4/1/1  shared slave port
- `i_wb_rdt`, `i_wb_ack`  in  32/1  shared slave response
- `o_timeout`  out  1  one-cycle pulse when the watchdog terminates a transfer
- `o_busy`  out  1  high whenever a master is granted

## Operation
- FSM states: IDLE, GNT_DM, GNT_D, GNT_I. Grant is registered.
- IDLE:
  - Sample the `cyc` inputs and go to the highest-priority requester next cycle (dm > dbus > ibus).
  - With no request, stay in IDLE.
- Slave outputs while granted: `o_wb_*` mirror the granted master's inputs combinationally. Masters hold their signals stable while `cyc` is high.
- Slave outputs for ibus grant: `o_wb_sel`=4'hf, `o_wb_we`=0, `o_wb_dat`=0.
- Slave outputs in IDLE: all `o_wb_*` = 0.
- Grant state, normal completion: when `i_wb_ack`=1, `o_<m>_ack`=1 and `o_<m>_rdt`=`i_wb_rdt` in the same cycle for the granted master only. The next state is IDLE.
- Non-granted masters always see ack=0 and rdt=0.
- Abort: if the granted master drops `cyc` before ack, go to IDLE next cycle with no ack and no timeout. `o_wb_cyc` follows the master low in that same cycle.
- Watchdog:
  - A 16-bit counter clears on entry to any grant state and increments each grant cycle without ack.
  - When the counter equals `TIMEOUT-1` and `i_wb_ack`=0:
    - `o_<m>_ack`=1 and `o_<m>_rdt`=0.
    - `o_timeout`=1 and `o_wb_cyc`=0 in that cycle.
    - The next state is IDLE.
- Ack in the timeout cycle: normal completion wins and `o_timeout` stays 0.
- Stray ack: `i_wb_ack` arriving in IDLE (late ack after a timeout) is ignored; no master ack is produced.
- No preemption: a higher-priority request arriving mid-transfer waits until the transfer completes.
- Simultaneous requests: resolved only in IDLE, by priority. The ibus may be starved by continuous dm/dbus traffic. This is acceptable because SERV never issues ibus and dbus together.
- `o_busy` = (state != IDLE).

## Timing
- Reset: asserting `i_rst_n`=0 takes effect immediately, asynchronously.
  - State becomes IDLE and the counter clears.
  - Every output is 0: all acks, all rdt, all `o_wb_*`, `o_timeout`, `o_busy`.
- Reset mid-transfer abandons the transfer silently.
- Deassertion is sampled on the next rising edge.
- Request sequence, with a request seen in IDLE at edge 0:
  - Grant state and `o_wb_cyc`=1 from cycle 1.
  - A zero-wait slave acks in cycle 1, so the master ack is in cycle 1.
  - Minimum latency from master `cyc` to `ack` is 1 cycle of arbitration plus the slave latency.
- After ack in cycle k, state is IDLE in cycle k+1. The earliest next grant is cycle k+2, so the maximum rate is one transfer per 2 cycles.
- SERV deasserts `cyc` the cycle after ack, so the IDLE cycle never re-grants a finished request.
- Timeout: with no slave ack, the forced ack occurs in the `TIMEOUT`-th grant cycle (cycle `TIMEOUT` after the grant edge).

## Test plan
- Reset: hold `i_rst_n`=0 with all `cyc`=1. Required: every output 0. Release; grant GNT_DM at the next edge.
- Single ibus read:
  - Stimulus: `i_ibus_adr`=32'h100 requested at cycle 0; slave acks in cycle 3 with rdt=32'hdeadbeef.
  - Required: `o_wb_adr`=32'h100 and sel=4'hf from cycle 1; `o_ibus_ack`=1 with rdt=32'hdeadbeef in cycle 3; `o_busy`=0 in cycle 4.
- Priority:
  - Stimulus: dm, dbus and ibus all request in the same IDLE cycle; each master drops `cyc` after its ack.
  - Required: grant order dm, dbus, ibus, with one IDLE cycle between transfers.
- Timeout:
  - Stimulus: TIMEOUT=4; dbus write adr=32'h200, dat=32'h12345678, sel=4'b0011, with no slave ack.
  - Required: in grant cycle 4, `o_dbus_ack`=1, `o_dbus_rdt`=0, `o_timeout`=1, `o_wb_cyc`=0.
  - Required: a stray `i_wb_ack` in the following IDLE cycle produces no master ack.
- Abort and boundary:
  - Abort: dm drops `cyc` in grant cycle 2. Required: IDLE next cycle with no ack.
  - Boundary: a slave ack coinciding with counter=`TIMEOUT-1`. Required: normal ack with data and `o_timeout`=0.
- Reset mid-transfer: assert `i_rst_n`=0 asynchronously while in GNT_D. Required: `o_wb_cyc` and `o_busy` fall without waiting for a clock edge.
